shape_int_mc: RTL and testbench

- Multi-channel, time-multiplexed leaky-integrator pulse shaper; next generation of the single-channel shaping integrator in the filters area.
- One arithmetic datapath serves CH channels. Each channel keeps its own accumulator in a register array.
- Adds beyond the single-channel block: a runtime leak shift, a pure-integrator mode, a per-sample channel clear, valid/channel tagging and per-channel sticky saturation flags.
- Sits between the ADC sample demux and the downstream trigger/peak logic.

---
 rtl/shape_pkg.sv | 52 +++++
 rtl/shape_leak_core.sv | 33 +++
 rtl/shape_int_mc.sv | 97 +++++++++
 tb/tb_shape_int_mc.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shape_pkg.sv
// Shared types, limits and arithmetic helpers for the multi-channel shaping integrator.
package shape_pkg;

   // Default sample/accumulator width and its signed limits.
   localparam int SHAPE_N = 16;
   localparam logic signed [SHAPE_N-1:0] MPOS = {1'b0, {(SHAPE_N-1){1'b1}}};
   localparam logic signed [SHAPE_N-1:0] MNEG = {1'b1, {(SHAPE_N-1){1'b0}}};

   // Internal arithmetic width: N up to 32 plus two guard bits, so a + D - L never wraps.
   localparam int WW = 34;
   typedef logic signed [WW-1:0] wide_t;

   typedef struct packed {
      wide_t val;
      logic  sat;
   } sat_res_t;

   // Clamp a wide value to the signed n-bit range and report whether clamping happened.
   function automatic sat_res_t sat_n(input wide_t v, input int n);
      wide_t    hi;
      wide_t    lo;
      sat_res_t r;
      hi = (34'sd1 <<< (n - 1)) - 34'sd1;
      lo = -hi - 34'sd1;
      if (v > hi) begin
         r.val = hi;
         r.sat = 1'b1;
      end else if (v < lo) begin
         r.val = lo;
         r.sat = 1'b1;
      end else begin
         r.val = v;
         r.sat = 1'b0;
      end
      return r;
   endfunction

   // Leak term: a >>> k, forced to +1 for small positive values so they reach 0; zero in pure mode.
   function automatic wide_t leak_n(input wide_t a, input logic [7:0] k, input logic mode);
      wide_t l;
      l = a >>> k;
      if (mode) begin
         l = 34'sd0;
      end else if ((l == 34'sd0) && (a > 34'sd0)) begin
         l = 34'sd1;
      end else begin
         l = l;
      end
      return l;
   endfunction

endpackage

// File: rtl/shape_leak_core.sv
// Combinational leak, add and clamp for one sample of one channel.
module shape_leak_core
   import shape_pkg::*;
#(
   parameter int N  = 16,
   parameter int KW = 4
) (
   input  logic signed [N-1:0]  a,
   input  logic signed [N-1:0]  d,
   input  logic        [KW-1:0] k,
   input  logic                 mode,
   output logic signed [N-1:0]  s_clamped,
   output logic                 sat
);

   wide_t    a_w_s;
   wide_t    d_w_s;
   wide_t    l_s;
   wide_t    sum_s;
   sat_res_t res_s;

   // Sign-extend, subtract the leak, then clamp back to N bits.
   always_comb begin
      a_w_s     = wide_t'(a);
      d_w_s     = wide_t'(d);
      l_s       = leak_n(a_w_s, 8'(k), mode);
      sum_s     = a_w_s + d_w_s - l_s;
      res_s     = sat_n(sum_s, N);
      s_clamped = res_s.val[N-1:0];
      sat       = res_s.sat;
   end

endmodule

// File: rtl/shape_int_mc.sv
// Time-multiplexed leaky-integrator pulse shaper: one datapath, CH per-channel accumulators.
module shape_int_mc
   import shape_pkg::*;
#(
   parameter int N  = 16,
   parameter int CH = 4,
   parameter int CW = 2,
   parameter int KW = 4
) (
   input  logic                 C,
   input  logic                 CLR,
   input  logic                 in_valid,
   input  logic        [CW-1:0] in_ch,
   input  logic                 in_clr,
   input  logic signed [N-1:0]  D,
   input  logic        [KW-1:0] k_shift,
   input  logic                 mode,
   input  logic                 sat_clr,
   output logic                 out_valid,
   output logic        [CW-1:0] out_ch,
   output logic signed [N-1:0]  Q,
   output logic                 out_sat,
   output logic        [CH-1:0] sat_sticky
);

   logic signed [N-1:0] acc_r [CH];

   logic signed [N-1:0] a_s;
   logic                ch_ok_s;
   logic                upd_s;
   logic signed [N-1:0] s_s;
   logic                sat_s;
   logic        [CH-1:0] sat_set_s;

   // Select the addressed channel's accumulator and decide whether this sample updates state.
   always_comb begin
      a_s       = {N{1'b0}};
      sat_set_s = {CH{1'b0}};
      ch_ok_s   = (32'(in_ch) < 32'(CH));
      upd_s     = in_valid && ch_ok_s;
      for (int i = 0; i < CH; i++) begin
         if (in_ch == CW'(i)) begin
            a_s          = acc_r[i];
            sat_set_s[i] = upd_s && !in_clr && sat_s;
         end else begin
            sat_set_s[i] = 1'b0;
         end
      end
   end

   shape_leak_core #(
      .N  (N),
      .KW (KW)
   ) u_core (
      .a         (a_s),
      .d         (D),
      .k         (k_shift),
      .mode      (mode),
      .s_clamped (s_s),
      .sat       (sat_s)
   );

   // Channel state, result register and sticky flags; a new saturation beats sat_clr.
   always_ff @(posedge C) begin
      if (CLR) begin
         for (int i = 0; i < CH; i++) begin
            acc_r[i] <= {N{1'b0}};
         end
         out_valid  <= 1'b0;
         out_ch     <= {CW{1'b0}};
         Q          <= {N{1'b0}};
         out_sat    <= 1'b0;
         sat_sticky <= {CH{1'b0}};
      end else begin
         for (int i = 0; i < CH; i++) begin
            if (upd_s && (in_ch == CW'(i))) begin
               acc_r[i] <= in_clr ? {N{1'b0}} : s_s;
            end else begin
               acc_r[i] <= acc_r[i];
            end
         end
         if (upd_s) begin
            out_valid <= 1'b1;
            out_ch    <= in_ch;
            Q         <= in_clr ? {N{1'b0}} : s_s;
            out_sat   <= in_clr ? 1'b0 : sat_s;
         end else begin
            out_valid <= 1'b0;
            out_ch    <= out_ch;
            Q         <= Q;
            out_sat   <= out_sat;
         end
         sat_sticky <= (sat_clr ? {CH{1'b0}} : sat_sticky) | sat_set_s;
      end
   end

endmodule

// File: tb/tb_shape_int_mc.sv
// Directed self-checking bench for shape_int_mc (N=16, CH=4, CW=3 so out-of-range channels are reachable).
module tb_shape_int_mc;

   logic               C = 1'b0;
   logic               CLR = 1'b1;
   logic               in_valid = 1'b0;
   logic        [2:0]  in_ch = 3'd0;
   logic               in_clr = 1'b0;
   logic signed [15:0] D = 16'sd0;
   logic        [3:0]  k_shift = 4'd0;
   logic               mode = 1'b0;
   logic               sat_clr = 1'b0;
   logic               out_valid;
   logic        [2:0]  out_ch;
   logic signed [15:0] Q;
   logic               out_sat;
   logic        [3:0]  sat_sticky;

   int errors = 0;
   int checks = 0;

   shape_int_mc #(.N(16), .CH(4), .CW(3), .KW(4)) dut (
      .C          (C),
      .CLR        (CLR),
      .in_valid   (in_valid),
      .in_ch      (in_ch),
      .in_clr     (in_clr),
      .D          (D),
      .k_shift    (k_shift),
      .mode       (mode),
      .sat_clr    (sat_clr),
      .out_valid  (out_valid),
      .out_ch     (out_ch),
      .Q          (Q),
      .out_sat    (out_sat),
      .sat_sticky (sat_sticky)
   );

   always #5 C = ~C;

   // Present one input cycle and return 1 time unit after the capturing edge.
   task automatic send(input logic v, input logic [2:0] ch, input logic clr, input logic signed [15:0] d);
      in_valid = v;
      in_ch    = ch;
      in_clr   = clr;
      D        = d;
      @(posedge C);
      #1;
   endtask

   task automatic do_reset();
      CLR = 1'b1;
      send(1'b0, 3'd0, 1'b0, 16'sd0);
      send(1'b0, 3'd0, 1'b0, 16'sd0);
      CLR = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (out_valid !== 1'b0 || Q !== 16'sd0 || out_ch !== 3'd0 || out_sat !== 1'b0 || sat_stick_ok(4'd0) == 1'b0) begin
         errors++;
         $display("FAIL reset: valid=%b Q=%0d ch=%0d sat=%b sticky=%b expected all zero", out_valid, Q, out_ch, out_sat, sat_sticky);
      end
   endtask

   function automatic logic sat_stick_ok(input logic [3:0] e);
      return (sat_sticky === e);
   endfunction

   task automatic test_step();
      logic signed [15:0] exp_q [9] = '{16'sd100, 16'sd150, 16'sd175, 16'sd188, 16'sd194, 16'sd197, 16'sd199, 16'sd200, 16'sd200};
      k_shift = 4'd1;
      mode    = 1'b0;
      for (int i = 0; i < 9; i++) begin
         send(1'b1, 3'd0, 1'b0, 16'sd100);
         checks++;
         if (Q !== exp_q[i] || out_valid !== 1'b1 || out_ch !== 3'd0 || out_sat !== 1'b0) begin
            errors++;
            $display("FAIL step[%0d]: Q=%0d valid=%b ch=%0d sat=%b expected Q=%0d valid=1 ch=0 sat=0", i, Q, out_valid, out_ch, out_sat, exp_q[i]);
         end
      end
   endtask

   task automatic test_decay();
      logic signed [15:0] exp_q [10] = '{16'sd100, 16'sd50, 16'sd25, 16'sd13, 16'sd7, 16'sd4, 16'sd2, 16'sd1, 16'sd0, 16'sd0};
      logic signed [15:0] exp_n [2]  = '{-16'sd1, 16'sd0};
      k_shift = 4'd1;
      for (int i = 0; i < 10; i++) begin
         send(1'b1, 3'd0, 1'b0, 16'sd0);
         checks++;
         if (Q !== exp_q[i] || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL decay[%0d]: Q=%0d valid=%b expected %0d", i, Q, out_valid, exp_q[i]);
         end
      end
      // Load -3 into ch2 through pure-integrator mode, then let it leak.
      mode = 1'b1;
      send(1'b1, 3'd2, 1'b0, -16'sd3);
      checks++;
      if (Q !== -16'sd3 || out_ch !== 3'd2) begin
         errors++;
         $display("FAIL neg_load: Q=%0d ch=%0d expected -3 ch=2", Q, out_ch);
      end
      mode = 1'b0;
      for (int i = 0; i < 2; i++) begin
         send(1'b1, 3'd2, 1'b0, 16'sd0);
         checks++;
         if (Q !== exp_n[i]) begin
            errors++;
            $display("FAIL neg_decay[%0d]: Q=%0d expected %0d", i, Q, exp_n[i]);
         end
      end
   endtask

   task automatic test_hold();
      send(1'b0, 3'd1, 1'b0, 16'sd555);
      checks++;
      if (out_valid !== 1'b0 || Q !== 16'sd0 || out_ch !== 3'd2) begin
         errors++;
         $display("FAIL hold: valid=%b Q=%0d ch=%0d expected valid=0 Q=0 ch=2", out_valid, Q, out_ch);
      end
   endtask

   task automatic test_saturation();
      logic signed [15:0] exp_q [4] = '{16'sd32767, 16'sd32767, -16'sd32768, -16'sd32768};
      logic        [2:0]  chs   [4] = '{3'd1, 3'd1, 3'd2, 3'd2};
      logic               exp_s [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
      logic signed [15:0] dv    [4] = '{16'sd32767, 16'sd32767, -16'sd32768, -16'sd32768};
      k_shift = 4'd15;
      for (int i = 0; i < 4; i++) begin
         send(1'b1, chs[i], 1'b0, dv[i]);
         checks++;
         if (Q !== exp_q[i] || out_sat !== exp_s[i] || out_ch !== chs[i]) begin
            errors++;
            $display("FAIL sat[%0d]: Q=%0d sat=%b ch=%0d expected Q=%0d sat=%b ch=%0d", i, Q, out_sat, out_ch, exp_q[i], exp_s[i], chs[i]);
         end
      end
      checks++;
      if (sat_sticky !== 4'b0110) begin
         errors++;
         $display("FAIL sticky_set: sticky=%b expected 0110", sat_sticky);
      end
      sat_clr = 1'b1;
      send(1'b0, 3'd0, 1'b0, 16'sd0);
      checks++;
      if (sat_sticky !== 4'b0000) begin
         errors++;
         $display("FAIL sticky_clr: sticky=%b expected 0000", sat_sticky);
      end
      // New saturation on ch1 in the same cycle as sat_clr: set wins.
      send(1'b1, 3'd1, 1'b0, 16'sd32767);
      checks++;
      if (sat_sticky !== 4'b0010 || out_sat !== 1'b1 || Q !== 16'sd32767) begin
         errors++;
         $display("FAIL sticky_setwins: sticky=%b sat=%b Q=%0d expected 0010 1 32767", sat_sticky, out_sat, Q);
      end
      sat_clr = 1'b0;
   endtask

   task automatic test_isolation();
      logic signed [15:0] e0 [5] = '{16'sd100, 16'sd175, 16'sd232, 16'sd274, 16'sd306};
      logic signed [15:0] e3 [5] = '{-16'sd40, -16'sd70, -16'sd92, -16'sd109, -16'sd121};
      do_reset();
      k_shift = 4'd2;
      mode    = 1'b0;
      for (int i = 0; i < 4; i++) begin
         send(1'b1, 3'd0, 1'b0, 16'sd100);
         checks++;
         if (Q !== e0[i] || out_ch !== 3'd0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL iso_ch0[%0d]: Q=%0d ch=%0d expected %0d ch=0", i, Q, out_ch, e0[i]);
         end
         send(1'b1, 3'd3, 1'b0, -16'sd40);
         checks++;
         if (Q !== e3[i] || out_ch !== 3'd3 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL iso_ch3[%0d]: Q=%0d ch=%0d expected %0d ch=3", i, Q, out_ch, e3[i]);
         end
      end
      send(1'b1, 3'd5, 1'b0, 16'sd1000);
      checks++;
      if (out_valid !== 1'b0 || Q !== -16'sd109 || out_ch !== 3'd3) begin
         errors++;
         $display("FAIL bad_ch5: valid=%b Q=%0d ch=%0d expected 0 -109 3", out_valid, Q, out_ch);
      end
      send(1'b1, 3'd4, 1'b0, 16'sd1000);
      checks++;
      if (out_valid !== 1'b0 || Q !== -16'sd109) begin
         errors++;
         $display("FAIL bad_ch4: valid=%b Q=%0d expected 0 -109", out_valid, Q);
      end
      send(1'b1, 3'd0, 1'b0, 16'sd100);
      checks++;
      if (Q !== e0[4]) begin
         errors++;
         $display("FAIL iso_after_ch0: Q=%0d expected %0d", Q, e0[4]);
      end
      send(1'b1, 3'd3, 1'b0, -16'sd40);
      checks++;
      if (Q !== e3[4]) begin
         errors++;
         $display("FAIL iso_after_ch3: Q=%0d expected %0d", Q, e3[4]);
      end
   endtask

   task automatic test_mode_clr();
      do_reset();
      mode    = 1'b1;
      k_shift = 4'd2;
      for (int i = 0; i < 5; i++) begin
         send(1'b1, 3'd0, 1'b0, 16'sd10);
         checks++;
         if (Q !== 16'(10 * (i + 1))) begin
            errors++;
            $display("FAIL mode[%0d]: Q=%0d expected %0d", i, Q, 10 * (i + 1));
         end
      end
      send(1'b1, 3'd0, 1'b1, 16'sd999);
      checks++;
      if (Q !== 16'sd0 || out_valid !== 1'b1 || out_sat !== 1'b0) begin
         errors++;
         $display("FAIL in_clr: Q=%0d valid=%b sat=%b expected 0 1 0", Q, out_valid, out_sat);
      end
      send(1'b1, 3'd0, 1'b0, 16'sd10);
      checks++;
      if (Q !== 16'sd10) begin
         errors++;
         $display("FAIL after_clr: Q=%0d expected 10", Q);
      end
      mode = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic signed [15:0] e0 [3] = '{16'sd100, 16'sd150, 16'sd175};
      do_reset();
      k_shift = 4'd15;
      send(1'b1, 3'd1, 1'b0, 16'sd32767);
      send(1'b1, 3'd1, 1'b0, 16'sd32767);
      k_shift = 4'd1;
      for (int i = 0; i < 3; i++) begin
         send(1'b1, 3'd0, 1'b0, 16'sd100);
         checks++;
         if (Q !== e0[i]) begin
            errors++;
            $display("FAIL mid_run[%0d]: Q=%0d expected %0d", i, Q, e0[i]);
         end
      end
      checks++;
      if (sat_sticky !== 4'b0010) begin
         errors++;
         $display("FAIL mid_sticky: sticky=%b expected 0010", sat_sticky);
      end
      CLR = 1'b1;
      send(1'b1, 3'd0, 1'b0, 16'sd100);
      CLR = 1'b0;
      checks++;
      if (out_valid !== 1'b0 || Q !== 16'sd0 || sat_sticky !== 4'b0000 || out_sat !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset: valid=%b Q=%0d sticky=%b sat=%b expected all zero", out_valid, Q, sat_sticky, out_sat);
      end
      send(1'b1, 3'd0, 1'b0, 16'sd100);
      checks++;
      if (Q !== 16'sd100 || out_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_restart: Q=%0d valid=%b expected 100 1", Q, out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_step();
      test_decay();
      test_hold();
      test_saturation();
      test_isolation();
      test_mode_clr();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
